mult_div_unit: RTL and testbench

Multiply/divide unit for the pipelined MIPS core. It consumes the 4-bit MDU operation code emitted by the decoder and executes mult/multu/div/divu as multi-cycle operations. It owns the architectural HI/LO registers, serves mfhi/mflo reads, and accepts mthi/mtlo writes. It sits in the E stage alongside the ALU, and its busy/start outputs feed the D-stage hazard unit.

---
 rtl/mult_div_unit.sv | 129 ++++++++++++
 tb/tb_mult_div_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - MIPS multiply/divide unit owning architectural HI/LO
//
// Executes mult/multu/div/divu as fixed-latency multi-cycle operations and
// serves mfhi/mflo/mthi/mtlo. The result is computed on the start edge and
// held in a pending register until the busy counter expires.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   mdu_op   - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo,
//              7 mthi, 8 mtlo, 9-15 none
//   rs_data  - dividend / multiplicand / mthi-mtlo source
//   rt_data  - divisor / multiplier
//   start    - combinational: multi-cycle op accepted this cycle
//   busy     - registered: multi-cycle op in flight
//   hi, lo   - registered architectural HI/LO
//   mf_data  - combinational mfhi/mflo read data (0 otherwise)
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

    logic [CNT_W-1:0] cnt;
    logic [63:0]      pending;
    logic             pending_nowrite;

    logic        is_mul;
    logic        is_div;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;
    logic [63:0] result;

    assign busy   = (cnt != '0);
    assign is_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
    assign is_div = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
    assign start  = (is_mul || is_div) && !busy;

    always_comb begin
        mf_data = 32'h0;
        if (mdu_op == OP_MFHI) begin
            mf_data = hi;
        end else if (mdu_op == OP_MFLO) begin
            mf_data = lo;
        end
    end

    // The low 64 bits of a product of two sign-extended (or zero-extended)
    // operands equal the signed (or unsigned) 32x32 product.
    always_comb begin
        mul_a   = (mdu_op == OP_MULT) ? {{32{rs_data[31]}}, rs_data} : {32'h0, rs_data};
        mul_b   = (mdu_op == OP_MULT) ? {{32{rt_data[31]}}, rt_data} : {32'h0, rt_data};
        product = mul_a * mul_b;
    end

    // Signed divide is done on magnitudes so that 0x80000000 / -1 falls out
    // naturally as 0x80000000 rem 0. A zero divisor is replaced by 1 only to
    // keep the divider defined; its result is never committed.
    always_comb begin
        div_zero = (rt_data == 32'h0);
        a_neg    = (mdu_op == OP_DIV) && rs_data[31];
        b_neg    = (mdu_op == OP_DIV) && rt_data[31];
        a_mag    = a_neg ? (32'h0 - rs_data) : rs_data;
        b_mag    = div_zero ? 32'h1 : (b_neg ? (32'h0 - rt_data) : rt_data);
        uq       = a_mag / b_mag;
        ur       = a_mag % b_mag;
        quot     = (a_neg ^ b_neg) ? (32'h0 - uq) : uq;
        rem      = a_neg ? (32'h0 - ur) : ur;
    end

    assign result = is_mul ? product : {rem, quot};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi              <= 32'h0;
            lo              <= 32'h0;
            cnt             <= '0;
            pending         <= 64'h0;
            pending_nowrite <= 1'b0;
        end else if (start) begin
            pending         <= result;
            pending_nowrite <= is_div && div_zero;
            cnt             <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (busy) begin
            cnt <= cnt - 1'b1;
            if ((cnt == CNT_W'(1)) && !pending_nowrite) begin
                hi <= pending[63:32];
                lo <= pending[31:0];
            end
        end else if (mdu_op == OP_MTHI) begin
            hi <= rs_data;
        end else if (mdu_op == OP_MTLO) begin
            lo <= rs_data;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        rst_n;
    logic [3:0]  mdu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    int checks;
    int errors;

    // Reference state: architectural HI/LO, the cycle index at which the
    // in-flight operation completes, and its result.
    int          cyc;
    int          m_end;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] p_hi;
    logic [31:0] p_lo;
    logic        p_write;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mdu_op  (mdu_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .start   (start),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .mf_data (mf_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Architectural result of a multi-cycle op from plain integer arithmetic.
    task automatic compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p_write = 1'b1;
        case (op)
            4'd1: begin
                r = sa * sb;
                u = 64'(r);
                p_hi = u[63:32];
                p_lo = u[31:0];
            end
            4'd2: begin
                u = {32'h0, a} * {32'h0, b};
                p_hi = u[63:32];
                p_lo = u[31:0];
            end
            4'd3: begin
                if (b == 0) begin
                    p_write = 1'b0;
                end else begin
                    r = sa / sb;
                    u = 64'(r);
                    p_lo = u[31:0];
                    r = sa % sb;
                    u = 64'(r);
                    p_hi = u[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    p_write = 1'b0;
                end else begin
                    p_lo = a / b;
                    p_hi = a % b;
                end
            end
        endcase
    endtask

    // One clock cycle with the given op: check combinational outputs before
    // the edge, advance the model, check registered outputs after it.
    task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic was_busy;
        logic exp_start;
        logic [31:0] exp_mf;
        @(negedge clk);
        mdu_op  = op;
        rs_data = a;
        rt_data = b;
        #1;
        was_busy  = (cyc < m_end);
        exp_start = (op >= 4'd1) && (op <= 4'd4) && !was_busy;
        exp_mf    = (op == 4'd5) ? m_hi : ((op == 4'd6) ? m_lo : 32'h0);
        check("start", {31'h0, start}, {31'h0, exp_start});
        check("mf_data", mf_data, exp_mf);
        @(posedge clk);
        cyc++;
        if (exp_start) begin
            compute(op, a, b);
            m_end = cyc + (((op == 4'd1) || (op == 4'd2)) ? MC : DC);
        end else if (was_busy) begin
            if ((cyc == m_end) && p_write) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (op == 4'd7) begin
            m_hi = a;
        end else if (op == 4'd8) begin
            m_lo = a;
        end
        #1;
        check("busy", {31'h0, busy}, {31'h0, (cyc < m_end)});
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'd0, $urandom, $urandom);
    endtask

    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    initial begin
        checks  = 0;
        errors  = 0;
        cyc     = 0;
        m_end   = 0;
        m_hi    = 0;
        m_lo    = 0;
        p_hi    = 0;
        p_lo    = 0;
        p_write = 0;
        mdu_op  = 4'd0;
        rs_data = 32'h0;
        rt_data = 32'h0;
        rst_n   = 1'b0;
        #12;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Signed multiply, then mfhi.
        step(4'd1, 32'hFFFFFFFD, 32'd5);
        idle(MC);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFF1);
        step(4'd5, 32'h0, 32'h0);
        check("mfhi_after_mult", mf_data, 32'hFFFFFFFF);

        // Unsigned multiply.
        step(4'd2, 32'hFFFFFFFF, 32'd2);
        idle(MC);
        check("multu_hi", hi, 32'h00000001);
        check("multu_lo", lo, 32'hFFFFFFFE);

        // Signed divide with a second div issued while busy.
        step(4'd3, 32'hFFFFFFF9, 32'd2);
        step(4'd3, 32'd100, 32'd3);
        idle(DC - 1);
        check("div_hi", hi, 32'hFFFFFFFF);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_not_extended", {31'h0, busy}, 32'h0);

        // Divide by zero leaves HI/LO untouched.
        step(4'd7, 32'h12345678, 32'h0);
        step(4'd8, 32'h9ABCDEF0, 32'h0);
        step(4'd4, 32'h55555555, 32'h0);
        idle(DC);
        check("div0_hi", hi, 32'h12345678);
        check("div0_lo", lo, 32'h9ABCDEF0);

        // Overflow divide.
        step(4'd3, 32'h80000000, 32'hFFFFFFFF);
        idle(DC);
        check("ovf_hi", hi, 32'h00000000);
        check("ovf_lo", lo, 32'h80000000);

        // Back-to-back start right at the first non-busy cycle.
        step(4'd2, 32'd3, 32'd4);
        idle(MC);
        step(4'd4, 32'd17, 32'd5);
        idle(DC);
        check("b2b_lo", lo, 32'd3);
        check("b2b_hi", hi, 32'd2);

        // Reset mid-operation at busy cycle 3.
        step(4'd1, 32'd7, 32'd9);
        idle(2);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        m_hi  = 0;
        m_lo  = 0;
        m_end = 0;
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(MC + 2);
        check("postrst_hi", hi, 32'h0);
        check("postrst_lo", lo, 32'h0);

        // Randomized traffic; every cycle is checked against the model.
        for (int i = 0; i < 3000; i++) begin
            r_op = 4'($urandom_range(0, 15));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'h0;
                1: begin r_a = 32'h80000000; r_b = 32'hFFFFFFFF; end
                2: r_b = 32'($urandom_range(1, 9));
                3: r_a = 32'($signed(-$urandom_range(1, 1000)));
                default: ;
            endcase
            step(r_op, r_a, r_b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
